// File: rtl/dcache_write_buffer.sv
// Circular store buffer between writeback and the dcache, with a two-state drain FSM and load-overlap probing.
// Store-to-load forwarding is compiled in only when DCACHE_WRITE_BUFFER_FWD_EN is defined.
module dcache_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_v_write,
  input  logic [31:0] i_wb_address,
  input  logic [31:0] i_wb_data,
  input  logic [1:0]  i_wb_datasize,
  output logic        o_wb_stall,
  output logic        o_mem_req,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_data,
  output logic [1:0]  o_mem_datasize,
  input  logic        i_mem_ack,
  input  logic [31:0] i_ld_address,
  output logic        o_ld_conflict,
  output logic        o_ld_fwd_v,
  output logic [31:0] o_ld_fwd_data,
  output logic        o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_addr [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic [1:0]      r_size [DEPTH];

  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   w_idx;
  logic            w_conflict;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = i_wb_v_write & ~w_full;
  assign w_pop       = (r_state == S_ISSUE) & i_mem_ack;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= w_count_nxt;
      case (r_state)
        S_IDLE:  if (w_push) r_state <= S_ISSUE;
        S_ISSUE: if (w_count_nxt == '0) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_wb_address;
      r_data[r_tail] <= i_wb_data;
      r_size[r_tail] <= i_wb_datasize;
    end
  end

  assign o_mem_req      = (r_state == S_ISSUE);
  assign o_mem_address  = o_mem_req ? r_addr[r_head] : 32'h0;
  assign o_mem_data     = o_mem_req ? r_data[r_head] : 32'h0;
  assign o_mem_datasize = o_mem_req ? r_size[r_head] : 2'b00;
  assign o_wb_stall     = w_full;
  assign o_empty        = (r_count == '0);

`ifdef DCACHE_WRITE_BUFFER_FWD_EN
  logic        w_fwd_v;
  logic [31:0] w_fwd_data;
`else
  logic [1:0]  w_unused_ld_lsb;
  assign w_unused_ld_lsb = i_ld_address[1:0];
`endif

  // Walk oldest to youngest so the last overlapping entry decides forwarding.
  always_comb begin
    w_conflict = 1'b0;
    w_idx      = r_head;
`ifdef DCACHE_WRITE_BUFFER_FWD_EN
    w_fwd_v    = 1'b0;
    w_fwd_data = 32'h0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if ((CW'(k) < r_count) && (r_addr[w_idx][31:2] == i_ld_address[31:2])) begin
        w_conflict = 1'b1;
`ifdef DCACHE_WRITE_BUFFER_FWD_EN
        w_fwd_v    = r_size[w_idx][1] && (r_addr[w_idx] == i_ld_address);
        w_fwd_data = w_fwd_v ? r_data[w_idx] : 32'h0;
`endif
      end
    end
  end

  assign o_ld_conflict = w_conflict;
`ifdef DCACHE_WRITE_BUFFER_FWD_EN
  assign o_ld_fwd_v    = w_fwd_v;
  assign o_ld_fwd_data = w_fwd_data;
`else
  assign o_ld_fwd_v    = 1'b0;
  assign o_ld_fwd_data = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Randomized and directed bench for dcache_write_buffer against a queue-based store model.
module tb_dcache_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_v_write;
  logic [31:0] wb_address;
  logic [31:0] wb_data;
  logic [1:0]  wb_datasize;
  logic        wb_stall;
  logic        mem_req;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic [1:0]  mem_datasize;
  logic        mem_ack;
  logic [31:0] ld_address;
  logic        ld_conflict;
  logic        ld_fwd_v;
  logic [31:0] ld_fwd_data;
  logic        empty;

  always #5 clk = ~clk;

  dcache_write_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_v_write(wb_v_write), .i_wb_address(wb_address), .i_wb_data(wb_data),
    .i_wb_datasize(wb_datasize), .o_wb_stall(wb_stall),
    .o_mem_req(mem_req), .o_mem_address(mem_address), .o_mem_data(mem_data),
    .o_mem_datasize(mem_datasize), .i_mem_ack(mem_ack),
    .i_ld_address(ld_address), .o_ld_conflict(ld_conflict),
    .o_ld_fwd_v(ld_fwd_v), .o_ld_fwd_data(ld_fwd_data), .o_empty(empty)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   fwd_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic        e_conf;
    logic        e_fv;
    logic [31:0] e_fd;
    e_conf = 1'b0; e_fv = 1'b0; e_fd = 32'h0;
    foreach (q[i]) begin
      if (q[i].a[31:2] == ld_address[31:2]) begin
        e_conf = 1'b1;
        e_fv   = fwd_en && q[i].s[1] && (q[i].a == ld_address);
        e_fd   = e_fv ? q[i].d : 32'h0;
      end
    end
    chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
    chk("empty",   32'(empty),   32'(q.size() == 0));
    chk("stall",   32'(wb_stall), 32'(q.size() == DEPTH));
    chk("mem_addr", mem_address, (q.size() != 0) ? q[0].a : 32'h0);
    chk("mem_data", mem_data,    (q.size() != 0) ? q[0].d : 32'h0);
    chk("mem_size", 32'(mem_datasize), (q.size() != 0) ? 32'(q[0].s) : 32'h0);
    chk("ld_conf",  32'(ld_conflict), 32'(e_conf));
    chk("fwd_v",    32'(ld_fwd_v), 32'(e_fv));
    chk("fwd_data", ld_fwd_data, e_fd);
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic step();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      do_push = wb_v_write && (q.size() < DEPTH);
      do_pop  = mem_ack && (q.size() != 0);
      e.a = wb_address; e.d = wb_data; e.s = wb_datasize;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    #1;
    check_all();
  endtask

  task automatic set_push(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    wb_v_write = v; wb_address = a; wb_data = d; wb_datasize = s;
  endtask

  task automatic drain();
    int budget;
    budget = 50;
    set_push(1'b0, 32'h0, 32'h0, 2'b00);
    mem_ack = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_budget", 32'(q.size()), 32'h0);
    mem_ack = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr(input int unsigned sel);
    logic [31:0] base;
    case (sel % 4)
      0: base = 32'h0000_2000;
      1: base = 32'h0000_2004;
      2: base = 32'h0000_3000;
      default: base = 32'h0000_1000;
    endcase
    return base | 32'($urandom_range(0, 3));
  endfunction

  logic [31:0] seq [12];

  initial begin
`ifdef DCACHE_WRITE_BUFFER_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    rst = 1'b1; mem_ack = 1'b0; ld_address = 32'h0;
    set_push(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    check_all();
    step(); step();
    rst = 1'b0;
    step();

    // Single store held until acknowledged.
    set_push(1'b1, 32'h1000, 32'hDEAD_BEEF, 2'b10);
    step();
    set_push(1'b0, 32'h0, 32'h0, 2'b00);
    chk("single_req", 32'(mem_req), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_hold_addr", mem_address, 32'h1000);
      chk("single_hold_data", mem_data, 32'hDEAD_BEEF);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("single_empty", 32'(empty), 32'h1);
    chk("single_req_off", 32'(mem_req), 32'h0);
    step();

    // Fill to full; the fifth store must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      set_push(1'b1, 32'h4000 + 32'(4 * i), 32'hA0 + 32'(i), 2'b01);
      step();
    end
    chk("fill_stall", 32'(wb_stall), 32'h1);
    set_push(1'b1, 32'h5000, 32'h55, 2'b10);
    mem_ack = 1'b0;
    step();
    set_push(1'b0, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_order", mem_data, 32'hA0 + 32'(i));
      mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("fill_dropped", 32'(empty), 32'h1);

    // Simultaneous push and pop across the pointer wrap.
    seq[0] = 32'h100; seq[1] = 32'h101;
    for (int i = 0; i < 10; i++) seq[i + 2] = 32'h200 + 32'(i);
    set_push(1'b1, 32'h6000, seq[0], 2'b10); step();
    set_push(1'b1, 32'h6004, seq[1], 2'b10); step();
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("wrap_order", mem_data, seq[i]);
      set_push(1'b1, 32'h7000 + 32'(4 * i), seq[i + 2], 2'b10);
      step();
      chk("wrap_level", 32'(q.size()), 32'h2);
      chk("wrap_stall", 32'(wb_stall), 32'h0);
    end
    chk("wrap_tail0", mem_data, seq[10]);
    drain();

    // Forwarding from the youngest exact dword match.
    set_push(1'b1, 32'h2000, 32'h1111_1111, 2'b10); step();
    set_push(1'b1, 32'h2000, 32'h2222_2222, 2'b10); step();
    set_push(1'b0, 32'h0, 32'h0, 2'b00);
    ld_address = 32'h2000;
    #1;
    check_all();
    chk("fwd_conf", 32'(ld_conflict), 32'h1);
    chk("fwd_valid", 32'(ld_fwd_v), fwd_en ? 32'h1 : 32'h0);
    chk("fwd_val", ld_fwd_data, fwd_en ? 32'h2222_2222 : 32'h0);
    ld_address = 32'h2002;
    #1;
    chk("part_conf", 32'(ld_conflict), 32'h1);
    chk("part_fwd", 32'(ld_fwd_v), 32'h0);
    ld_address = 32'h2008;
    #1;
    chk("miss_conf", 32'(ld_conflict), 32'h0);
    drain();

    // Reset while issuing with three stores pending.
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h8000 + 32'(4 * i), 32'hC0 + 32'(i), 2'b10);
      step();
    end
    set_push(1'b0, 32'h0, 32'h0, 2'b00);
    chk("pre_rst_req", 32'(mem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_drop", 32'(mem_req), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    q.delete();
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_push(1'($urandom_range(0, 1)), pick_addr($urandom), $urandom, 2'($urandom_range(0, 3)));
      mem_ack    = ($urandom_range(0, 2) != 0);
      ld_address = pick_addr($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_write_buffer.md
DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of store entries; legal values 2, 4, 8, 16.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 WB_V_WRITE  in  1  validated store request from writeback.
REQ-005 WB_ADDRESS  in  32  store byte address.
REQ-006 WB_DATA  in  32  store data, right-aligned.
REQ-007 WB_DATASIZE  in  2  store size: 00 byte, 01 word, 10 dword; 11 is treated as dword.
REQ-008 WB_STALL  out  1  buffer full; writeback holds its store.
REQ-009 MEM_REQ / MEM_ADDRESS / MEM_DATA / MEM_DATASIZE  out  1/32/32/2  head-entry write request to the dcache.
REQ-010 MEM_ACK  in  1  dcache accepted the current MEM_REQ.
REQ-011 LD_ADDRESS  in  32  load address probed against pending stores.
REQ-012 LD_CONFLICT  out  1  a pending store overlaps the load's dword.
REQ-013 LD_FWD_V / LD_FWD_DATA  out  1/32  store-to-load forward result.
REQ-014 EMPTY  out  1  no pending stores.

Function
REQ-015 The buffer SHALL be a circular FIFO of DEPTH entries (addr, data, size) with head and tail pointers and a count of width log2(DEPTH)+1.
REQ-016 Push: when WB_V_WRITE=1 and the registered full flag is 0, the entry SHALL be written at tail and tail SHALL advance modulo DEPTH.
REQ-017 When full, a push SHALL be ignored, even if a pop occurs in the same cycle; WB_STALL SHALL equal (count==DEPTH).
REQ-018 Drain FSM SHALL have exactly two states: IDLE (count==0, MEM_REQ=0) and ISSUE (MEM_REQ=1, MEM_* driven from the head entry).
REQ-019 In ISSUE, MEM_ADDRESS, MEM_DATA and MEM_DATASIZE SHALL stay stable until the cycle in which MEM_ACK=1.
REQ-020 MEM_ACK=1 in ISSUE SHALL pop the head in that cycle; the FSM SHALL go to IDLE if the post-update count is 0, otherwise stay in ISSUE.
REQ-021 MEM_ACK in IDLE SHALL be ignored.
REQ-022 IDLE->ISSUE SHALL occur the cycle after the first push, giving a push-to-MEM_REQ latency of 1 cycle.
REQ-023 A simultaneous push and pop SHALL leave count unchanged.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.
REQ-025 LD_CONFLICT SHALL be combinational: 1 if any valid entry has addr[31:2]==LD_ADDRESS[31:2].
REQ-026 EMPTY SHALL equal (count==0).

Reset
REQ-027 RST=1 SHALL asynchronously clear count, head and tail, and force the FSM to IDLE.
REQ-028 During and after reset: MEM_REQ=0, WB_STALL=0, EMPTY=1, LD_CONFLICT=0, LD_FWD_V=0, LD_FWD_DATA=0, MEM_ADDRESS/MEM_DATA=0, MEM_DATASIZE=00.
REQ-029 A reset asserted mid-ISSUE SHALL drop MEM_REQ immediately and discard all pending stores.

Configuration
REQ-030 Macro DCACHE_WRITE_BUFFER_FWD_EN SHALL control store-to-load forwarding.
REQ-031 With the macro defined: LD_FWD_V=1 when the youngest overlapping entry has dword size and addr==LD_ADDRESS exactly; LD_FWD_DATA SHALL then be that entry's data, and 0 otherwise.
REQ-032 Without the macro: LD_FWD_V and LD_FWD_DATA SHALL be constant 0; LD_CONFLICT is unaffected.

Verification
REQ-033 Single store: push addr 0x1000, data 0xDEADBEEF, size 10 with MEM_ACK=0 -> next cycle MEM_REQ=1 with those values; hold 3 cycles stable; MEM_ACK=1 -> next cycle EMPTY=1, MEM_REQ=0.
REQ-034 Fill: with DEPTH=4, push 4 stores with MEM_ACK=0 -> WB_STALL=1; a 5th push is dropped; ack 4 times -> data arrives in push order.
REQ-035 Wrap and simultaneous events: push and ack in the same cycle for 10 consecutive cycles -> count stays constant and order is preserved across the pointer wrap.
REQ-036 Forwarding: pending entries 0x2000/0x11111111 (dword) then 0x2000/0x22222222 (dword); probe LD_ADDRESS 0x2000 -> LD_CONFLICT=1, and with the macro LD_FWD_V=1, LD_FWD_DATA=0x22222222 (without the macro: 0/0); probe 0x2002 -> conflict=1, LD_FWD_V=0.
REQ-037 Reset mid-operation: assert RST with 3 entries pending and MEM_REQ=1 -> MEM_REQ=0 in the same cycle, EMPTY=1; a later MEM_ACK pulse has no effect.
